audio_tone_source: RTL

//  Generates test-tone PCM for the HDMI audio path: 16-bit signed left/right samples

---
 rtl/audio_tone_source.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/audio_tone_source.sv
// Test-tone PCM source for the HDMI audio path.
// Phase-accumulator oscillator with click-free gain ramping.
module audio_tone_source #(
  parameter int PHASE_WIDTH  = 24,
  parameter bit RIGHT_INVERT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] phase_step,
  input  logic [7:0]             volume,
  input  logic [1:0]             waveform,
  input  logic                   sample_strobe,
  output logic signed [15:0]     sample_left,
  output logic signed [15:0]     sample_right,
  output logic                   active
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    PLAY,
    RAMP_DOWN
  } state_e;

  state_e state_q, state_d;

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [7:0]             gain_q, gain_d;
  logic [1:0]             wave_sel_q, wave_sel_d;
  logic signed [15:0]     left_q, left_d;
  logic signed [15:0]     right_q, right_d;

  logic [PHASE_WIDTH:0]   sum;
  logic                   wrap;
  logic [7:0]             gain_inc;
  logic [15:0]            t;
  logic signed [15:0]     wave;
  logic signed [24:0]     prod;
  logic signed [24:0]     shifted;
  logic signed [15:0]     left_calc;
  logic signed [15:0]     right_calc;

  assign sum      = {1'b0, phase_q} + {1'b0, phase_step};
  assign wrap     = sum[PHASE_WIDTH];
  assign gain_inc = (gain_q == 8'hff) ? 8'hff : gain_q + 8'd1;
  assign t        = phase_q[PHASE_WIDTH-1 -: 16];

  // Waveform shape from the top 16 phase bits
  always_comb begin
    wave = '0;
    unique case (wave_sel_q)
      2'd0: wave = t[15] ? 16'sh8000 : 16'sh7fff;
      2'd1: wave = t[15] ? ({~t[14:0], 1'b0} ^ 16'h8000)
                         : ({t[14:0], 1'b0} ^ 16'h8000);
      2'd2: wave = t ^ 16'h8000;
      default: wave = '0;
    endcase
  end

  // Gain scaling with floor rounding; result always fits 16 bits
  always_comb begin
    prod       = wave * $signed({1'b0, gain_q});
    shifted    = prod >>> 8;
    left_calc  = shifted[15:0];
    right_calc = left_calc;
    if (RIGHT_INVERT) begin
      right_calc = (left_calc == 16'sh8000) ? 16'sh7fff : -left_calc;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
        end else if (sample_strobe ? (gain_inc >= volume)
                                   : (volume < gain_q)) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!enable) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_d = RAMP_UP;
        end else if (gain_q == 8'd0) begin
          state_d = IDLE;
        end else if (sample_strobe && gain_q == 8'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    active = (state_q != IDLE);
  end

  // Per-sample datapath: sample from pre-update phase/gain, then advance
  always_comb begin
    phase_d    = phase_q;
    gain_d     = gain_q;
    wave_sel_d = wave_sel_q;
    left_d     = left_q;
    right_d    = right_q;
    if (state_q == IDLE) begin
      wave_sel_d = waveform;
      if (sample_strobe) begin
        left_d  = '0;
        right_d = '0;
      end
    end else if (sample_strobe) begin
      left_d  = left_calc;
      right_d = right_calc;
      phase_d = sum[PHASE_WIDTH-1:0];
      if (wrap) wave_sel_d = waveform;
      unique case (state_q)
        RAMP_UP: gain_d = gain_inc;
        PLAY: begin
          if (gain_q < volume) begin
            gain_d = gain_q + 8'd1;
          end else if (gain_q > volume) begin
            gain_d = gain_q - 8'd1;
          end
        end
        RAMP_DOWN: begin
          if (gain_q != 8'd0) gain_d = gain_q - 8'd1;
        end
        default: gain_d = gain_q;
      endcase
    end
    if (state_d == IDLE) phase_d = '0;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      gain_q     <= '0;
      wave_sel_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      gain_q     <= gain_d;
      wave_sel_q <= wave_sel_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;

endmodule
